// File: rtl/regfile_port_arbiter_pkg.sv
// Shared widths and the issue-stage record for the register-file port arbiter.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 31;
    localparam int ID_W     = 3;    // enough for up to 8 requesters

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [ID_W-1:0]   id;
        logic              zero;
    } issue_t;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Requester-side bus: per-requester command handshake plus the shared read-response return.
interface regfile_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/regfile_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, ptr moves past the winner on advance.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] win;
    logic             found;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        sum   = '0;
        idx   = '0;
        win   = '0;
        found = 1'b0;
        // Walk offsets 0..NUM_REQ-1 from ptr, wrapping modulo NUM_REQ (not necessarily a power of two).
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = idx;
            end
        end
        if (advance && found) begin
            ptr_d = (win == PTR_W'(NUM_REQ-1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register file's single write port and single read port among NUM_REQ requesters.
module regfile_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_port_arbiter_if.slave bus,
    output logic                 rf_wr_en,
    output logic [ADDR_W-1:0]    rf_wr_addr,
    output logic [DATA_W-1:0]    rf_wr_data,
    output logic [ADDR_W-1:0]    rf_rd_sel,
    input  logic [DATA_W-1:0]    rf_rd_data
);
    import regfile_pkg::*;

    logic [NUM_REQ-1:0] grant;
    logic               hs;
    issue_t             cmd;
    issue_t             chain [NUM_REQ+1];

    logic               wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]  rd_sel_q,  rd_sel_d;
    logic               rd_pend_q, rd_pend_d;
    logic [ID_W-1:0]    rd_id_q,   rd_id_d;
    logic               rd_zero_q, rd_zero_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .advance (hs),
        .grant   (grant)
    );

    assign bus.req_ready = grant & {NUM_REQ{reset_n}};
    assign hs            = |(bus.req_valid & bus.req_ready);

    // Grant is one-hot, so a select chain picks the winner's command without priority effects.
    assign chain[0] = '0;
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic [ADDR_W-1:0] addr_i;
        assign addr_i = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign chain[gi+1] = grant[gi]
            ? issue_t'{we:   bus.req_we[gi],
                       addr: addr_i,
                       data: bus.req_wdata[gi*DATA_W +: DATA_W],
                       id:   ID_W'(gi),
                       zero: (addr_i == ADDR_W'(ZERO_REG))}
            : chain[gi];
        assign rsp_valid_d[gi] = rd_pend_q & (rd_id_q == ID_W'(gi));
    end
    assign cmd = chain[NUM_REQ];

    always_comb begin
        wr_en_d   = hs & cmd.we & ~cmd.zero;
        wr_addr_d = wr_en_d ? cmd.addr : wr_addr_q;
        wr_data_d = wr_en_d ? cmd.data : wr_data_q;
        rd_pend_d = hs & ~cmd.we;
        rd_sel_d  = rd_pend_d ? cmd.addr : rd_sel_q;
        rd_id_d   = rd_pend_d ? cmd.id   : rd_id_q;
        rd_zero_d = rd_pend_d ? cmd.zero : rd_zero_q;
        rsp_data_d = rsp_data_q;
        if (rd_pend_q) begin
            rsp_data_d = rd_zero_q ? '0 : rf_rd_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_sel_q    <= '0;
            rd_pend_q   <= 1'b0;
            rd_id_q     <= '0;
            rd_zero_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_sel_q    <= rd_sel_d;
            rd_pend_q   <= rd_pend_d;
            rd_id_q     <= rd_id_d;
            rd_zero_q   <= rd_zero_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rf_wr_en      = wr_en_q;
    assign rf_wr_addr    = wr_addr_q;
    assign rf_wr_data    = wr_data_q;
    assign rf_rd_sel     = rd_sel_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Round-robin arbiter that shares the single write port and single read port of the 32×32-bit register file among `NUM_REQ` requesters.
- Each requester issues a read or write command with a valid/ready handshake.
- Writes drive the register file's write port one cycle later.
- Reads drive the 5-bit read select one cycle later; the muxed data is captured and returned to the originating requester on the following cycle.
- The block sits between requesters (decode, debug, load/store writeback) and the register file plus its 32:1 read mux array.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `DATA_W`, 32: register width
- `ADDR_W`, 5: register address width
- `ZERO_REG`, 31: hardwired-zero register index

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  command valid per requester
- `req_ready`  out  NUM_REQ  one-hot grant; handshake = valid & ready
- `req_we`  in  NUM_REQ  1 = write, 0 = read
- `req_addr`  in  NUM_REQ*ADDR_W  register index; requester i occupies bits [i*ADDR_W +: ADDR_W]
- `req_wdata`  in  NUM_REQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W]
- `rsp_valid`  out  NUM_REQ  one-hot read-response strobe
- `rsp_data`  out  DATA_W  read data, valid when any `rsp_valid` bit is set
- `rf_wr_en`  out  1  register-file write enable
- `rf_wr_addr`  out  ADDR_W  write index
- `rf_wr_data`  out  DATA_W  write data
- `rf_rd_sel`  out  ADDR_W  read-mux select
- `rf_rd_data`  in  DATA_W  combinational read-mux output for `rf_rd_sel`

## Operation
- **Grant**
  - `req_ready` is combinational from `req_valid` and the priority pointer `ptr`.
  - The first valid requester at or after `ptr` (mod NUM_REQ) is granted.
  - At most one grant per cycle; `req_ready` is 0 when no request is valid.
- **Pointer**
  - On a handshake by requester g, `ptr` becomes (g+1) mod NUM_REQ.
  - With no handshake, `ptr` holds.
  - Reset value 0.
- **Fairness:** a continuously valid requester is granted within NUM_REQ cycles.
- **Issue stage** (registered from the handshake cycle):
  - Write to `ZERO_REG`: the handshake completes but `rf_wr_en` stays 0, so the write is silently dropped.
  - Other writes: `rf_wr_en`=1, with `rf_wr_addr` and `rf_wr_data` taken from the granted requester.
  - Read: `rf_rd_sel` = address. The granted ID and a zero flag (address == `ZERO_REG`) are registered alongside it.
- **Response stage**
  - `rsp_data` ← 0 if the zero flag is set, otherwise `rf_rd_data`.
  - `rsp_valid[id]` ← 1 for exactly one cycle.
- **No backpressure on responses:** a requester must accept `rsp_valid` unconditionally.
- **Idle values:** `rf_rd_sel` holds its last value when idle. `rf_wr_en` is 0 in every cycle without a write issue.
- **Reset** (`reset_n` low, any time):
  - `ptr`, `rf_wr_en`, `rf_wr_addr`, `rf_wr_data`, `rf_rd_sel`, `rsp_valid`, `rsp_data` all go to 0.
  - In-flight reads are dropped and produce no response.
  - `req_ready` is 0 while `reset_n` is low.

## Timing
- Handshake at cycle T.
  - Write: `rf_wr_en` high during T+1; the register updates at the T+1→T+2 edge.
  - Read: `rf_rd_sel` valid during T+1; `rsp_valid`/`rsp_data` valid during T+2.
- Throughput: one command per cycle, any read/write mix.
- Read-after-write: a write handshaken at T followed by a read of the same register at T+1 returns the new value. No bypass is needed because the write commits before that read's select cycle.
- Write followed by a read from a different requester in the next cycle: same guarantee, since ordering is by handshake cycle.
- Back-to-back reads from one requester produce responses on consecutive cycles, in order.

## Structure
- Package `regfile_pkg` holds `ADDR_W`, `DATA_W`, `NUM_REGS` (32), `ZERO_REG`, and a typedef for the issue-stage record: `we`, `addr`, `data`, `id`, `zero`.
- Sub-module `rr_arbiter`:
  - parameter `NUM_REQ`
  - inputs `req`, `advance`
  - output one-hot `grant`
  - owns `ptr` and its async reset.
- The top level contains the issue and response registers and the ID-indexed muxing of `req_*`.

## Test plan
- **Reset mid-read:** handshake a read of r5, assert `reset_n` low at T+1 → no `rsp_valid` at T+2, all outputs 0, `ptr`=0.
- **Write then read:** requester 0 writes 0xDEADBEEF to r7 at T, requester 1 reads r7 at T+1 → `rf_wr_en`=1 with addr 7 at T+1; `rsp_valid`=4'b0010 with `rsp_data`=0xDEADBEEF at T+3.
- **Zero register:** write 0x1234 to r31 → `rf_wr_en` stays 0; a subsequent read of r31 returns 0 even if `rf_rd_data` is forced to 0xFFFFFFFF.
- **Round-robin:** all four requesters valid continuously from reset → grants 0,1,2,3,0,… with exactly one `req_ready` bit per cycle.
- **Pointer hold:** requester 2 alone valid (grant, `ptr`→3), then idle 3 cycles, then requesters 1 and 3 valid → requester 3 is granted first.
- **Throughput:** 16 back-to-back reads of r0..r15 by requester 1 → 16 consecutive `rsp_valid` cycles, in address order, data matching the model.
